// File: rtl/dmem_ctrl.sv
// Data-memory responder for the D-cache refill and write-through port.
// Byte-addressed RAM; line reads reply after LATENCY wait cycles.
module dmem_ctrl #(
  parameter int ADDR_BIT = 10,
  parameter int LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        write_i,
  input  logic [31:0] write_data_i,
  input  logic [3:0]  write_mask_i,
  output logic        rep_o,
  output logic [63:0] rep_data_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    READ_RESP,
    WRITE
  } state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_BIT-4:0] base_q, base_d;
  logic [7:0] mem [2**ADDR_BIT];
  logic wr_en;
  logic [ADDR_BIT-3:0] wword;
  logic unused_addr;

  assign unused_addr = ^{addr_i[31:ADDR_BIT], addr_i[1:0]};
  assign wword = addr_i[ADDR_BIT-1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (write_i) begin
          wr_en   = 1'b1;
          state_d = WRITE;
        end else if (req_i) begin
          base_d  = addr_i[ADDR_BIT-1:3];
          cnt_d   = LAT;
          state_d = (LAT == 4'd0) ? READ_RESP : READ_WAIT;
        end
      end
      READ_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = READ_RESP;
      end
      READ_RESP: state_d = IDLE;
      WRITE:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
    end
  end

  // Big-endian within the word: mask[3] targets the lowest byte address.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      if (write_mask_i[3]) mem[{wword, 2'd0}] <= write_data_i[31:24];
      if (write_mask_i[2]) mem[{wword, 2'd1}] <= write_data_i[23:16];
      if (write_mask_i[1]) mem[{wword, 2'd2}] <= write_data_i[15:8];
      if (write_mask_i[0]) mem[{wword, 2'd3}] <= write_data_i[7:0];
    end
  end

  assign rep_o  = (state_q == READ_RESP);
  assign busy_o = (state_q != IDLE);

  for (genvar k = 0; k < 8; k++) begin : g_rep
    assign rep_data_o[8*k +: 8] = rep_o ? mem[{base_q, 3'(k)}] : 8'h00;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: vector table plus multi-cycle
// sequences for priority, reset and zero-latency behaviour.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, write_i;
  logic [31:0] addr_i, write_data_i;
  logic [3:0]  write_mask_i;
  logic        rep_o, busy_o;
  logic [63:0] rep_data_o;

  logic        req0, write0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  mask0;
  logic        rep0, busy0;
  logic [63:0] rdata0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_BIT(10), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i),
    .write_i(write_i), .write_data_i(write_data_i),
    .write_mask_i(write_mask_i), .rep_o(rep_o),
    .rep_data_o(rep_data_o), .busy_o(busy_o)
  );

  dmem_ctrl #(.ADDR_BIT(10), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_i(req0), .addr_i(addr0),
    .write_i(write0), .write_data_i(wdata0),
    .write_mask_i(mask0), .rep_o(rep0),
    .rep_data_o(rdata0), .busy_o(busy0)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m);
    @(negedge clk);
    write_i = 1'b1;
    addr_i = a;
    write_data_i = d;
    write_mask_i = m;
    @(posedge clk);
    #1 write_i = 1'b0;
    @(negedge clk);
    chk("wr_busy", 64'(busy_o), 64'd1);
    @(negedge clk);
    chk("wr_idle", 64'(busy_o), 64'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [63:0] exp);
    int n;
    bit got;
    @(negedge clk);
    req_i = 1'b1;
    addr_i = a;
    @(posedge clk);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (rep_o) begin
        got = 1'b1;
        req_i = 1'b0;
        chk("rd_lat", 64'(n), 64'd3);
        chk("rd_data", rep_data_o, exp);
      end else if (!busy_o) begin
        chk("rd_busy_wait", 64'(busy_o), 64'd1);
      end
    end
    req_i = 1'b0;
    if (!got) chk("rd_timeout", 64'(n), 64'd3);
    @(negedge clk);
    chk("rd_after_busy", 64'(busy_o), 64'd0);
    chk("rd_after_data", rep_data_o, 64'd0);
  endtask

  initial begin
    int n;
    int reps;
    logic [63:0] cap;

    vecs[0]  = '{1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 64'd0};
    vecs[1]  = '{1'b1, 32'h104, 32'h01234567, 4'hF, 64'd0};
    vecs[2]  = '{1'b0, 32'h103, 32'd0, 4'h0, 64'h67452301EFBEADDE};
    vecs[3]  = '{1'b1, 32'h104, 32'h000000AA, 4'b0001, 64'd0};
    vecs[4]  = '{1'b0, 32'h100, 32'd0, 4'h0, 64'hAA452301EFBEADDE};
    vecs[5]  = '{1'b1, 32'h100, 32'h12345678, 4'b0000, 64'd0};
    vecs[6]  = '{1'b0, 32'h507, 32'd0, 4'h0, 64'hAA452301EFBEADDE};
    vecs[7]  = '{1'b1, 32'h110, 32'h00000000, 4'hF, 64'd0};
    vecs[8]  = '{1'b1, 32'h114, 32'h00000000, 4'hF, 64'd0};
    vecs[9]  = '{1'b1, 32'h112, 32'hA1B2C3D4, 4'b1010, 64'd0};
    vecs[10] = '{1'b1, 32'h117, 32'h00EE0000, 4'b0100, 64'd0};
    vecs[11] = '{1'b0, 32'h115, 32'd0, 4'h0, 64'h0000EE0000C300A1};

    rst = 1'b1;
    req_i = 0; write_i = 0; addr_i = 0; write_data_i = 0; write_mask_i = 0;
    req0 = 0; write0 = 0; addr0 = 0; wdata0 = 0; mask0 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_rep", 64'(rep_o), 64'd0);
    chk("reset_data", rep_data_o, 64'd0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].mask);
      else do_read(vecs[i].addr, vecs[i].exp);
    end

    // Write and read together: write first, held read follows once.
    @(negedge clk);
    req_i = 1'b1; write_i = 1'b1;
    addr_i = 32'h108; write_data_i = 32'h11223344; write_mask_i = 4'hF;
    @(posedge clk);
    #1 write_i = 1'b0;
    reps = 0; cap = '0; n = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (rep_o) begin
        reps++;
        cap = rep_data_o;
        n = c;
        req_i = 1'b0;
      end
    end
    req_i = 1'b0;
    chk("prio_reps", 64'(reps), 64'd1);
    chk("prio_cycle", 64'(n), 64'd5);
    chk("prio_data", {32'd0, cap[31:0]}, 64'h44332211);

    // Reset during READ_WAIT aborts the read.
    @(negedge clk);
    req_i = 1'b1; addr_i = 32'h100;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0;
    chk("midrd_busy", 64'(busy_o), 64'd1);
    rst = 1'b1;
    reps = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrd_busy_after", 64'(busy_o), 64'd0);
    chk("midrd_data_after", rep_data_o, 64'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rep_o) reps++;
    end
    chk("midrd_no_rep", 64'(reps), 64'd0);
    do_read(32'h100, 64'hAA452301EFBEADDE);

    // Zero latency instance with address wrap.
    @(negedge clk);
    write0 = 1'b1; addr0 = 32'h100; wdata0 = 32'hDEADBEEF; mask0 = 4'hF;
    @(posedge clk);
    #1 write0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    write0 = 1'b1; addr0 = 32'h104; wdata0 = 32'h01234567;
    @(posedge clk);
    #1 write0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("lat0_idle", 64'(busy0), 64'd0);
    req0 = 1'b1; addr0 = 32'h500;
    @(posedge clk);
    @(negedge clk);
    req0 = 1'b0;
    chk("lat0_rep", 64'(rep0), 64'd1);
    chk("lat0_data", rdata0, 64'h67452301EFBEADDE);
    @(negedge clk);
    chk("lat0_rep_off", 64'(rep0), 64'd0);
    chk("lat0_busy_off", 64'(busy0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Memory-side responder for the data cache's refill/write-through port. It accepts 64-bit line-fill read requests and masked 32-bit write-through requests from the cache, backs them with an internal byte-addressed RAM, and returns each line after a programmable latency with a one-cycle reply strobe. It sits between the data cache and the top-level memory model and owns all data-memory state.

## Interface
- ADDR_BIT, 10: byte-address width of the backing RAM (2^ADDR_BIT bytes); upper address bits are ignored, so addresses wrap.
- LATENCY, 2: wait cycles between read acceptance and reply; legal range 0..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_i  in  1  read (line-fill) request, level.
- addr_i  in  32  request address; addr_i[2:0] ignored for reads, addr_i[1:0] ignored for writes.
- write_i  in  1  write-through request, level.
- write_data_i  in  32  write data.
- write_mask_i  in  4  byte enables for writes.
- rep_o  out  1  one-cycle read-reply strobe.
- rep_data_o  out  64  line data, valid while rep_o=1.
- busy_o  out  1  high whenever the block is not in IDLE; new requests are not accepted while high.

## Operation
- States: IDLE, READ_WAIT, READ_RESP, WRITE.
- Byte order: line base B = {addr_i[ADDR_BIT-1:3], 3'b000}; rep_data_o[8k+7:8k] = mem[B+k] for k = 0..7.
- Write: word base W = {addr_i[ADDR_BIT-1:2], 2'b00}; mask[3] writes write_data_i[31:24] to mem[W+0], mask[2] writes [23:16] to W+1, mask[1] writes [15:8] to W+2, mask[0] writes [7:0] to W+3. Mask 4'b0000 writes nothing but still takes the WRITE cycle.
- IDLE: if write_i=1, commit write at this edge and go to WRITE (write has priority over a simultaneous req_i). Else if req_i=1, latch line base, load counter with LATENCY, and go to READ_WAIT (or READ_RESP directly when LATENCY=0). Otherwise stay.
- READ_WAIT: decrement counter; go to READ_RESP when it reaches 1 on the current edge (i.e. after LATENCY cycles in READ_WAIT).
- READ_RESP: rep_o=1; rep_data_o is formed from RAM contents at this cycle. Next state is IDLE.
- WRITE: one cycle, busy_o=1, then IDLE.
- Inputs are ignored outside IDLE. The requester must hold write_i or req_i until busy_o is low and the request is accepted. The requester drops req_i in the cycle following rep_o; if req_i is still high in IDLE, the block treats it as a new read.
- Reset values: state IDLE, rep_o=0, rep_data_o=0, busy_o=0, counter 0. RAM contents are not altered by reset. Reset mid-read aborts the read, and no rep_o is issued.
- rep_data_o returns to 0 in every cycle except READ_RESP.

## Timing
- Read accepted at edge T (IDLE, req_i=1, write_i=0): busy_o=1 from T+1 through T+1+LATENCY; rep_o=1 in cycle T+1+LATENCY only; IDLE at T+2+LATENCY. With LATENCY=0, rep_o is asserted in cycle T+1.
- Write accepted at edge T: RAM is updated at T; busy_o=1 in cycle T+1; IDLE at T+2. A read accepted at T+2 observes the written data.
- Simultaneous req_i and write_i in IDLE at T: the write is served at T, and the read is accepted at T+2 at the earliest.
- Throughput: one read per LATENCY+2 cycles; one write per 2 cycles.

## Test plan
- Reset check: assert rst for 2 cycles mid-simulation -> rep_o=0, rep_data_o=0, busy_o=0 in the cycle after the reset edge.
- Write then read: write 0xDEADBEEF mask 4'hF at 0x100; write 0x01234567 mask 4'hF at 0x104; read at 0x103 with LATENCY=2 -> rep_o exactly 3 cycles after acceptance, rep_data_o=0x67452301EFBEADDE, busy_o low in the next cycle.
- Partial mask: after the previous step, write 0x000000AA mask 4'b0001 at 0x104; read 0x100 -> rep_data_o=0xAA452301EFBEADDE.
- Priority and hold: in IDLE, drive req_i=1, write_i=1, addr 0x108, data 0x11223344, mask 4'hF; drop write_i after acceptance and hold req_i -> write is committed first, rep_data_o[31:0]=0x44332211, and rep_o is asserted exactly once.
- Wrap and latency 0: with LATENCY=0, read 0x500 -> rep_o in the cycle after acceptance, with data equal to the line at 0x100.
- Reset mid-read: assert rst during READ_WAIT -> rep_o is never asserted for that request, busy_o=0, and a subsequent read returns correct data.
